ex_mem_wb_pipe: RTL and testbench

- Downstream receiver of the EX stage output. Captures the EX results (ALU result, store data, instruction word, link PC) into the EX/MEM pipeline register.
- Performs the data-memory access in MEM. Registers the writeback bundle (destination register, write data, write enable) into MEM/WB for the register file.
- Exports MEM-stage forwarding values so the hazard unit can bypass results back into EX.

---
 rtl/ex_mem_wb_pipe.sv | 127 ++++++++++++
 tb/tb_ex_mem_wb_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with an internal word-addressed data memory.
// Define DM_TRACE_EN to print store and register-write trace lines in simulation.
module ex_mem_wb_pipe #(
  parameter int          DM_ADDR_W = 10,
  parameter logic [31:0] RESET_PC8 = 32'h0000_3008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUoutE,
  input  logic [31:0] RTE,
  input  logic [31:0] IRE,
  input  logic [31:0] PC8E,
  input  logic        en,
  input  logic        flush,
  output logic [31:0] IRM,
  output logic [31:0] ALUoutM,
  output logic [31:0] FwdDataM,
  output logic [4:0]  FwdA3M,
  output logic [31:0] IRW,
  output logic [4:0]  A3W,
  output logic [31:0] WDW,
  output logic        RegWriteW
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam int         DM_DEPTH = 2 ** DM_ADDR_W;

  function automatic logic [4:0] dest_reg(input logic [31:0] ir);
    logic [5:0] op;
    logic [5:0] func;
    op       = ir[31:26];
    func     = ir[5:0];
    dest_reg = 5'd0;
    if (op == OP_RTYPE && ir != 32'd0 && func != FN_JR) dest_reg = ir[15:11];
    else if (op == OP_ADDI || op == OP_ADDIU || op == OP_ORI ||
             op == OP_LUI  || op == OP_LW) dest_reg = ir[20:16];
    else if (op == OP_JAL) dest_reg = 5'd31;
  endfunction

  logic [31:0]          rt_m;
  logic [31:0]          pc8_m;
  logic [31:0]          dm [DM_DEPTH];
  logic [5:0]           op_m;
  logic [4:0]           a3_m;
  logic [DM_ADDR_W-1:0] dm_idx;
  logic                 is_lw_m;
  logic                 is_sw_m;
  logic                 is_jal_m;

  always_comb begin
    op_m     = IRM[31:26];
    a3_m     = dest_reg(IRM);
    dm_idx   = ALUoutM[DM_ADDR_W+1:2];
    is_lw_m  = (op_m == OP_LW);
    is_sw_m  = (op_m == OP_SW);
    is_jal_m = (op_m == OP_JAL);
    FwdDataM = is_jal_m ? pc8_m : ALUoutM;
    // A load's data only exists after the memory edge, so it is never offered for bypass.
    FwdA3M   = is_lw_m ? 5'd0 : a3_m;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      IRM     <= '0;
      ALUoutM <= '0;
      rt_m    <= '0;
      pc8_m   <= RESET_PC8;
    end else if (en) begin
      if (flush) begin
        IRM     <= '0;
        ALUoutM <= '0;
        rt_m    <= '0;
        pc8_m   <= PC8E;
      end else begin
        IRM     <= IRE;
        ALUoutM <= ALUoutE;
        rt_m    <= RTE;
        pc8_m   <= PC8E;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DM_DEPTH; i++) dm[i] <= '0;
    end else if (en && is_sw_m) begin
      dm[dm_idx] <= rt_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      IRW       <= '0;
      A3W       <= '0;
      WDW       <= '0;
      RegWriteW <= 1'b0;
    end else if (en) begin
      IRW       <= IRM;
      A3W       <= a3_m;
      RegWriteW <= (a3_m != 5'd0);
      if (is_lw_m)       WDW <= dm[dm_idx];
      else if (is_jal_m) WDW <= pc8_m;
      else               WDW <= ALUoutM;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && en) begin
      if (is_sw_m)
        $display("%d@%h: *%h <= %h", $time, pc8_m - 32'd8, {ALUoutM[31:2], 2'b00}, rt_m);
      if (a3_m != 5'd0)
        $display("%d@%h: $%d <= %h", $time, pc8_m - 32'd8, a3_m,
                 is_lw_m ? dm[dm_idx] : (is_jal_m ? pc8_m : ALUoutM));
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Randomized bench for ex_mem_wb_pipe: directed scenarios then random traffic,
// every output compared each cycle against a behavioural pipeline model.
module tb_ex_mem_wb_pipe;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUoutE, RTE, IRE, PC8E;
  logic        en, flush;
  logic [31:0] IRM, ALUoutM, FwdDataM, IRW, WDW;
  logic [4:0]  FwdA3M, A3W;
  logic        RegWriteW;

  ex_mem_wb_pipe dut (
    .clk(clk), .reset(reset), .ALUoutE(ALUoutE), .RTE(RTE), .IRE(IRE), .PC8E(PC8E),
    .en(en), .flush(flush), .IRM(IRM), .ALUoutM(ALUoutM), .FwdDataM(FwdDataM),
    .FwdA3M(FwdA3M), .IRW(IRW), .A3W(A3W), .WDW(WDW), .RegWriteW(RegWriteW)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: one record per stage plus the memory image.
  logic [31:0] m_ir, m_alu, m_rt, m_pc8;
  logic [31:0] w_ir, w_wd;
  logic [4:0]  w_a3;
  logic        w_rw;
  logic [31:0] mem [DEPTH];
  logic [31:0] pc_ctr = 32'h0000_3000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [4:0] writes_to(input logic [31:0] ir);
    case (ir[31:26])
      6'd0:                             return (ir == 0 || ir[5:0] == 6'h08) ? 5'd0 : ir[15:11];
      6'h08, 6'h09, 6'h0d, 6'h0f, 6'h23: return ir[20:16];
      6'h03:                            return 5'd31;
      default:                          return 5'd0;
    endcase
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd4, rt, 16'h0010};
  endfunction

  task automatic step(input logic rst_n, input logic en_i, input logic fl_i,
                      input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] rt);
    reset = rst_n; en = en_i; flush = fl_i;
    IRE = ir; ALUoutE = alu; RTE = rt; PC8E = pc_ctr;
    @(posedge clk);
    if (!rst_n) begin
      m_ir = 0; m_alu = 0; m_rt = 0; m_pc8 = 32'h0000_3008;
      w_ir = 0; w_wd = 0; w_a3 = 0; w_rw = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 0;
    end else if (en_i) begin
      w_ir = m_ir;
      w_a3 = writes_to(m_ir);
      w_rw = (w_a3 != 0);
      if (m_ir[31:26] == 6'h23)      w_wd = mem[word_of(m_alu)];
      else if (m_ir[31:26] == 6'h03) w_wd = m_pc8;
      else                           w_wd = m_alu;
      if (m_ir[31:26] == 6'h2b) mem[word_of(m_alu)] = m_rt;
      if (fl_i) begin m_ir = 0; m_alu = 0; m_rt = 0; end
      else begin m_ir = ir; m_alu = alu; m_rt = rt; end
      m_pc8 = pc_ctr;
    end
    pc_ctr = pc_ctr + 4;
    #1;
    check("IRM", IRM, m_ir);
    check("ALUoutM", ALUoutM, m_alu);
    check("FwdDataM", FwdDataM, (m_ir[31:26] == 6'h03) ? m_pc8 : m_alu);
    check("FwdA3M", {27'd0, FwdA3M}, (m_ir[31:26] == 6'h23) ? 32'd0 : {27'd0, writes_to(m_ir)});
    check("IRW", IRW, w_ir);
    check("A3W", {27'd0, A3W}, {27'd0, w_a3});
    check("WDW", WDW, w_wd);
    check("RegWriteW", {31'd0, RegWriteW}, {31'd0, w_rw});
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] rt);
    step(1'b1, 1'b1, 1'b0, ir, alu, rt);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] r;
    r = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 10))
      0:  return rtype(r, 6'h21);
      1:  return rtype(5'd9, 6'h08);
      2:  return itype(6'h08, r);
      3:  return itype(6'h0d, r);
      4:  return itype(6'h0f, r);
      5, 6: return itype(6'h23, r);
      7, 8: return itype(6'h2b, r);
      9:  return {6'h03, 26'h0000c04};
      default: return ($urandom_range(0, 1) == 0) ? 32'd0 : itype(6'h04, r);
    endcase
  endfunction

  initial begin
    // Reset then idle; loads of words 0..3 must return zero.
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1234, 32'h5678);
    check("rst_IRM", IRM, 32'd0);
    check("rst_WDW", WDW, 32'd0);
    check("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    for (int i = 0; i < 4; i++) issue(itype(6'h23, 5'(i + 1)), 32'(4 * i), 0);
    issue(0, 0, 0); issue(0, 0, 0);

    // Store then load of the same word, unaligned address.
    issue(itype(6'h2b, 5'd2), 32'h0000_0008, 32'hDEAD_BEEF);
    issue(itype(6'h23, 5'd5), 32'h0000_000B, 0);
    issue(0, 0, 0);
    check("ld_A3W", {27'd0, A3W}, 32'd5);
    check("ld_WDW", WDW, 32'hDEAD_BEEF);
    check("ld_RegWriteW", {31'd0, RegWriteW}, 32'd1);

    // Bypass values and the jal link.
    issue(rtype(5'd3, 6'h21), 32'h12, 0);
    check("byp_FwdA3M", {27'd0, FwdA3M}, 32'd3);
    check("byp_FwdDataM", FwdDataM, 32'h12);
    pc_ctr = 32'h0000_3010;
    issue({6'h03, 26'h0000c10}, 32'h99, 0);
    check("jal_FwdA3M", {27'd0, FwdA3M}, 32'd31);
    check("jal_FwdDataM", FwdDataM, 32'h3010);
    issue(0, 0, 0);
    check("jal_WDW", WDW, 32'h3010);

    // Stall with a store in MEM, then flush with a pending R-type.
    issue(itype(6'h2b, 5'd1), 32'h20, 32'h5555_0000);
    step(1'b1, 1'b0, 1'b1, rtype(5'd6, 6'h21), 32'h7, 0);
    step(1'b1, 1'b0, 1'b0, rtype(5'd6, 6'h21), 32'h7, 0);
    step(1'b1, 1'b1, 1'b1, rtype(5'd6, 6'h21), 32'h7, 0);
    check("fl_IRM", IRM, 32'd0);
    check("fl_FwdA3M", {27'd0, FwdA3M}, 32'd0);
    issue(itype(6'h23, 5'd2), 32'h20, 0);
    check("fl_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    issue(0, 0, 0);
    check("stall_store", WDW, 32'h5555_0000);

    // Address wrap: word 1 reached through an address beyond the depth.
    issue(itype(6'h2b, 5'd1), 32'(4 * DEPTH + 4), 32'h0000_A5A5);
    issue(itype(6'h23, 5'd7), 32'h4, 0);
    issue(0, 0, 0);
    check("wrap_WDW", WDW, 32'h0000_A5A5);

    // R-type with rd = 0 never writes.
    issue(rtype(5'd0, 6'h21), 32'h44, 0);
    issue(0, 0, 0);
    check("rd0_RegWriteW", {31'd0, RegWriteW}, 32'd0);

    // Reset while a store sits in MEM drops it.
    issue(itype(6'h2b, 5'd1), 32'h10, 32'h7777_7777);
    step(1'b0, 1'b1, 1'b0, 0, 0, 0);
    issue(itype(6'h23, 5'd3), 32'h10, 0);
    issue(0, 0, 0);
    check("rst_store_dropped", WDW, 32'd0);

    // Random traffic over a small window of words with random upper address bits.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] alu;
      alu = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
           rand_ir(), alu, $urandom());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
